// File: rtl/sdram_arbit.sv
// Fixed-priority SDRAM bus arbiter: init sequencer owns the bus until init_end,
// then refresh > write > read, one owner at a time, with an ARB/NOP cycle between grants.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        arb_clk,
  input  logic        arb_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_bank,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_sdram_cmd,
  input  logic [1:0]  wr_sdram_bank,
  input  logic [12:0] wr_sdram_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_sdram_cmd,
  input  logic [1:0]  rd_sdram_bank,
  input  logic [12:0] rd_sdram_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr,
  inout  wire  [15:0] sdram_dq,
  output logic [15:0] rd_dq_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_aref_en;
  logic        r_wr_en;
  logic        r_rd_en;
  logic [3:0]  w_cmd;
  logic [1:0]  w_bank;
  logic [12:0] w_addr;
  logic        w_dq_oe;

  // Grants are registered from the next state so they rise and fall on the
  // same edge the FSM enters and leaves the owner state.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_state   <= IDLE;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aref_en <= (w_next == AREF);
      r_wr_en   <= (w_next == WRITE);
      r_rd_en   <= (w_next == READ);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (init_end) w_next = ARB;
      ARB: begin
        if (aref_req)      w_next = AREF;
        else if (wr_req)   w_next = WRITE;
        else if (rd_req)   w_next = READ;
      end
      AREF:  if (aref_end) w_next = ARB;
      WRITE: if (wr_end)   w_next = ARB;
      READ:  if (rd_end)   w_next = ARB;
      default:             w_next = IDLE;
    endcase
    // Losing init_end overrides everything, including an owner's end pulse.
    if (r_state != IDLE && !init_end) w_next = IDLE;
  end

  always_comb begin
    w_cmd  = CMD_NOP;
    w_bank = 2'b00;
    w_addr = 13'h0000;
    case (r_state)
      IDLE: begin
        w_cmd  = init_cmd;
        w_bank = init_bank;
        w_addr = init_addr;
      end
      AREF: begin
        w_cmd  = aref_cmd;
        w_bank = aref_bank;
        w_addr = aref_addr;
      end
      WRITE: begin
        w_cmd  = wr_sdram_cmd;
        w_bank = wr_sdram_bank;
        w_addr = wr_sdram_addr;
      end
      READ: begin
        w_cmd  = rd_sdram_cmd;
        w_bank = rd_sdram_bank;
        w_addr = rd_sdram_addr;
      end
      default: ;
    endcase
  end

  assign w_dq_oe    = (r_state == WRITE) && wr_sdram_en;
  assign sdram_dq   = w_dq_oe ? wr_sdram_data : 16'hzzzz;
  assign rd_dq_out  = sdram_dq;
  assign sdram_cmd  = w_cmd;
  assign sdram_bank = w_bank;
  assign sdram_addr = w_addr;
  assign aref_en    = r_aref_en;
  assign wr_en      = r_wr_en;
  assign rd_en      = r_rd_en;

endmodule
